// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin front end sharing one 2-cycle add/sub ALU chip
// Tagged, credit-limited response FIFO; optional ALU_ARB_STATS_EN adds accept/stall counters.
module alu_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int RSP_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [2*NREQ-1:0]         req_op,
  input  logic [WIDTH*NREQ-1:0]     req_a,
  input  logic [WIDTH*NREQ-1:0]     req_b,
  output logic [NREQ-1:0]           req_ready,
  output logic [1:0]                alu_op,
  output logic [WIDTH-1:0]          alu_a,
  output logic [WIDTH-1:0]          alu_b,
  output logic                      alu_in_valid,
  input  logic [WIDTH-1:0]          alu_out,
  input  logic                      alu_out_valid,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  output logic                      seq_err
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [31:0]               stat_issued,
  output logic [31:0]               stat_stall
`endif
);

  localparam int ID_W  = $clog2(NREQ);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam logic [ID_W:0]  NREQ_V  = (ID_W+1)'(NREQ);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(RSP_DEPTH);

  logic [1:0]       w_op_arr [NREQ];
  logic [WIDTH-1:0] w_a_arr  [NREQ];
  logic [WIDTH-1:0] w_b_arr  [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_op_arr[gi] = req_op[2*gi +: 2];
    assign w_a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
    assign w_b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
  end

  logic [ID_W-1:0]   r_ptr;
  logic              r_s1_vld, r_s2_vld;
  logic [ID_W-1:0]   r_s1_id, r_s2_id;
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_seq_err;
  logic [ID_W-1:0]   r_mem_id   [RSP_DEPTH];
  logic [WIDTH-1:0]  r_mem_data [RSP_DEPTH];

  logic [2*NREQ-1:0] w_req2;
  logic [NREQ-1:0]   w_rot;
  logic [ID_W:0]     w_base, w_off, w_sum, w_wrap;
  logic [ID_W-1:0]   w_winner;
  logic              w_found;
  logic [1:0]        w_inflight;
  logic [CNT_W:0]    w_occ;
  logic              w_credit, w_accept, w_push, w_pop;

  // Rotate the request vector so bit 0 is the requester just after the last winner.
  assign w_req2 = {req_valid, req_valid};
  assign w_base = {1'b0, r_ptr} + (ID_W+1)'(1);
  assign w_rot  = NREQ'(w_req2 >> w_base);

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (ID_W+1)'(k);
      end
    end
  end

  assign w_sum    = w_base + w_off;
  assign w_wrap   = (w_sum >= NREQ_V) ? (w_sum - NREQ_V) : w_sum;
  assign w_winner = ID_W'(w_wrap);

  // Queued plus in-flight results must always fit in the FIFO, so a stalled consumer loses nothing.
  assign w_inflight = {1'b0, r_s1_vld} + {1'b0, r_s2_vld};
  assign w_occ      = (CNT_W+1)'(r_count) + (CNT_W+1)'(w_inflight);
  assign w_credit   = (w_occ < DEPTH_V);
  assign w_accept   = !rst && w_found && w_credit;

  always_comb begin
    req_ready    = '0;
    alu_in_valid = 1'b0;
    alu_op       = 2'h0;
    alu_a        = '0;
    alu_b        = '0;
    if (w_accept) begin
      req_ready[w_winner] = 1'b1;
      alu_in_valid        = 1'b1;
      alu_op              = w_op_arr[w_winner];
      alu_a               = w_a_arr[w_winner];
      alu_b               = w_b_arr[w_winner];
    end
  end

  assign rsp_valid = !rst && (r_count != '0);
  assign rsp_id    = r_mem_id[r_rptr];
  assign rsp_data  = r_mem_data[r_rptr];
  assign seq_err   = r_seq_err;
  assign w_push    = r_s2_vld;
  assign w_pop     = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= ID_W'(NREQ - 1);
      r_s1_vld  <= 1'b0;
      r_s1_id   <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_id   <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_seq_err <= 1'b0;
    end else begin
      if (w_accept) r_ptr <= w_winner;
      r_s1_vld <= w_accept;
      r_s1_id  <= w_winner;
      r_s2_vld <= r_s1_vld;
      r_s2_id  <= r_s1_id;
      if (alu_out_valid != r_s2_vld) r_seq_err <= 1'b1;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_id[r_wptr]   <= r_s2_id;
      r_mem_data[r_wptr] <= alu_out;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [31:0] r_stat_issued, r_stat_stall;
  logic        w_stall;

  assign w_stall     = !rst && (|req_valid) && !w_credit;
  assign stat_issued = r_stat_issued;
  assign stat_stall  = r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_accept && r_stat_issued != 32'hFFFF_FFFF) r_stat_issued <= r_stat_issued + 32'd1;
      if (w_stall && r_stat_stall != 32'hFFFF_FFFF)   r_stat_stall  <= r_stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - self-checking bench for alu_rr_arbiter with a 2-cycle chip model
module tb_alu_rr_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [7:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [3:0]  req_ready;
  logic [1:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_in_valid, alu_out_valid;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        seq_err;
`ifdef ALU_ARB_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_in_valid(alu_in_valid),
    .alu_out(alu_out), .alu_out_valid(alu_out_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .seq_err(seq_err)
`ifdef ALU_ARB_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Chip stand-in: input register then output register, reset by the same rst.
  logic       c_v1, c_vout, inject = 1'b0;
  logic [1:0] c_op1;
  logic [7:0] c_a1, c_b1, c_out;

  function automatic logic [7:0] chip_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      2'h1:    return a + b;
      2'h2:    return a + ~b + 8'd1;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      c_v1 <= 1'b0; c_vout <= 1'b0; c_out <= 8'h00;
    end else begin
      c_v1 <= alu_in_valid; c_op1 <= alu_op; c_a1 <= alu_a; c_b1 <= alu_b;
      c_vout <= c_v1; c_out <= chip_calc(c_op1, c_a1, c_b1);
    end
  end
  assign alu_out = c_out;
  assign alu_out_valid = c_vout | inject;

  function automatic logic [7:0] ref_result(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int r;
    if (op == 2'h1) r = (int'(a) + int'(b)) % 256;
    else if (op == 2'h2) r = (int'(a) - int'(b) + 256) % 256;
    else r = 0;
    return 8'(r);
  endfunction

  task automatic drive_idle();
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i] = 1'b1; req_op[2*i +: 2] = op; req_a[8*i +: 8] = a; req_b[8*i +: 8] = b;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1; drive_idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_req(i, 2'h1, 8'($urandom), 8'($urandom));
    #1;
    checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
    checks++; if (alu_in_valid !== 1'b0) begin failures++; $display("FAIL reset_in_valid got=%0b exp=0", alu_in_valid); end
    checks++; if ({alu_op, alu_a, alu_b} !== 18'h0) begin failures++; $display("FAIL reset_alu_bus got op=%0h a=%0h b=%0h exp 0", alu_op, alu_a, alu_b); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    @(negedge clk); #1;
    checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL reset_seq_err got=%0b exp=0", seq_err); end
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL reset_hold got rv=%0b rdy=%0h exp 0", rsp_valid, req_ready); end
    @(negedge clk); rst = 1'b0; drive_idle();
  endtask

  task automatic test_single_ops();
    int         t_id [5] = '{0, 2, 2, 1, 3};
    logic [1:0] t_op [5] = '{2'h1, 2'h2, 2'h2, 2'h0, 2'h3};
    logic [7:0] t_a  [5] = '{8'h05, 8'h02, 8'h80, 8'hFF, 8'h12};
    logic [7:0] t_b  [5] = '{8'h03, 8'h05, 8'h01, 8'h01, 8'h34};
    logic [7:0] t_r  [5] = '{8'h08, 8'hFD, 8'h7F, 8'h00, 8'h00};
    rsp_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk); drive_idle(); set_req(t_id[t], t_op[t], t_a[t], t_b[t]); #1;
      checks++;
      if (req_ready !== 4'(1 << t_id[t])) begin failures++; $display("FAIL single_grant t=%0d got=%0h exp=%0h", t, req_ready, 4'(1 << t_id[t])); end
      checks++;
      if (alu_in_valid !== 1'b1 || alu_op !== t_op[t] || alu_a !== t_a[t] || alu_b !== t_b[t]) begin
        failures++;
        $display("FAIL single_issue t=%0d got v=%0b op=%0h a=%0h b=%0h exp v=1 op=%0h a=%0h b=%0h", t, alu_in_valid, alu_op, alu_a, alu_b, t_op[t], t_a[t], t_b[t]);
      end
      for (int j = 1; j <= 4; j++) begin
        @(negedge clk); drive_idle(); #1;
        checks++;
        if (rsp_valid !== (j == 3)) begin failures++; $display("FAIL single_rsp_valid t=%0d cyc=%0d got=%0b exp=%0b", t, j, rsp_valid, (j == 3)); end
        if (j == 3) begin
          checks++;
          if (rsp_id !== 2'(t_id[t]) || rsp_data !== t_r[t]) begin failures++; $display("FAIL single_rsp t=%0d got id=%0d data=%0h exp id=%0d data=%0h", t, rsp_id, rsp_data, t_id[t], t_r[t]); end
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [12];
    logic [1:0] op;
    logic [7:0] a, b;
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); drive_idle();
      if (k < 12) begin
        for (int i = 0; i < 4; i++) begin
          op = 2'($urandom_range(1, 2)); a = 8'($urandom); b = 8'($urandom);
          set_req(i, op, a, b);
          if (i == k % 4) exp_d[k] = ref_result(op, a, b);
        end
      end
      #1;
      if (k < 12) begin
        checks++;
        if (req_ready !== 4'(1 << (k % 4))) begin failures++; $display("FAIL rr_grant k=%0d got=%0h exp=%0h", k, req_ready, 4'(1 << (k % 4))); end
      end
      checks++;
      if (rsp_valid !== (k >= 3 && k < 15)) begin failures++; $display("FAIL rr_rsp_valid k=%0d got=%0b exp=%0b", k, rsp_valid, (k >= 3 && k < 15)); end
      if (k >= 3 && k < 15) begin
        checks++;
        if (rsp_id !== 2'((k - 3) % 4) || rsp_data !== exp_d[k-3]) begin
          failures++; $display("FAIL rr_rsp k=%0d got id=%0d data=%0h exp id=%0d data=%0h", k, rsp_id, rsp_data, (k - 3) % 4, exp_d[k-3]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [4];
    logic [1:0] op;
    logic [7:0] a, b;
    int acc = 0;
    apply_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); drive_idle();
      for (int i = 0; i < 4; i++) begin
        op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom);
        set_req(i, op, a, b);
        if (k < 4 && i == k) exp_d[k] = ref_result(op, a, b);
      end
      #1;
      if (req_ready != 4'b0) acc++;
      checks++;
      if (req_ready !== ((k < 4) ? 4'(1 << k) : 4'b0)) begin failures++; $display("FAIL bp_grant k=%0d got=%0h exp=%0h", k, req_ready, (k < 4) ? 4'(1 << k) : 4'b0); end
    end
    checks++;
    if (acc != 4) begin failures++; $display("FAIL bp_accepts got=%0d exp=4", acc); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); drive_idle(); rsp_ready = 1'b1; #1;
      checks++;
      if (rsp_valid !== (k < 4)) begin failures++; $display("FAIL bp_rsp_valid k=%0d got=%0b exp=%0b", k, rsp_valid, (k < 4)); end
      if (k < 4) begin
        checks++;
        if (rsp_id !== 2'(k) || rsp_data !== exp_d[k]) begin failures++; $display("FAIL bp_pop k=%0d got id=%0d data=%0h exp id=%0d data=%0h", k, rsp_id, rsp_data, k, exp_d[k]); end
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    rsp_ready = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk); drive_idle();
      case (k)
        0: set_req(0, 2'h1, 8'h11, 8'h22);
        2: set_req(1, 2'h2, 8'h33, 8'h01);
        3: set_req(2, 2'h1, 8'h40, 8'h02);
        4: begin rst = 1'b1; set_req(3, 2'h1, 8'h01, 8'h01); end
        5: begin rst = 1'b0; rsp_ready = 1'b1; end
        default: ;
      endcase
      #1;
      if (k == 0 || k == 2 || k == 3) begin
        checks++;
        if (req_ready !== 4'(1 << (k == 0 ? 0 : k - 1))) begin failures++; $display("FAIL mid_grant k=%0d got=%0h", k, req_ready); end
      end
      if (k == 3) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin failures++; $display("FAIL mid_queued got rv=%0b id=%0d exp rv=1 id=0", rsp_valid, rsp_id); end
      end
      if (k == 4) begin
        checks++;
        if (req_ready !== 4'b0 || alu_in_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_issue got rdy=%0h v=%0b exp 0", req_ready, alu_in_valid); end
      end
      if (k >= 4) begin
        checks++;
        if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_no_rsp k=%0d got=%0b exp=0", k, rsp_valid); end
      end
    end
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL mid_seq_err got=%0b exp=0", seq_err); end
  endtask

  typedef struct { int id; logic [7:0] data; int avail; } rsp_t;

  task automatic test_random();
    rsp_t       m_q[$];
    rsp_t       e;
    int         m_ptr, m_out, m_cyc, win;
    logic [3:0] exp_ready;
    logic       exp_rv, do_pop;
    apply_reset();
    m_ptr = NREQ - 1; m_out = 0; m_cyc = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk); drive_idle();
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 99) < 55) set_req(i, 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
      rsp_ready = ((n / 50) % 2 == 0) ? ($urandom_range(0, 99) < 85) : ($urandom_range(0, 99) < 20);
      #1;
      win = -1;
      if (m_out < RSP_DEPTH)
        for (int k = 1; k <= NREQ; k++)
          if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      exp_ready = (win >= 0) ? 4'(1 << win) : 4'b0;
      checks++;
      if (req_ready !== exp_ready || alu_in_valid !== (win >= 0)) begin
        failures++; $display("FAIL rand_grant n=%0d got rdy=%0h v=%0b exp rdy=%0h", n, req_ready, alu_in_valid, exp_ready);
      end
      checks++;
      if (win >= 0) begin
        if ({alu_op, alu_a, alu_b} !== {req_op[2*win +: 2], req_a[8*win +: 8], req_b[8*win +: 8]}) begin
          failures++; $display("FAIL rand_alu_bus n=%0d got op=%0h a=%0h b=%0h win=%0d", n, alu_op, alu_a, alu_b, win);
        end
      end else if ({alu_op, alu_a, alu_b} !== 18'h0) begin
        failures++; $display("FAIL rand_alu_idle n=%0d got op=%0h a=%0h b=%0h exp 0", n, alu_op, alu_a, alu_b);
      end
      exp_rv = (m_q.size() > 0) && (m_q[0].avail <= m_cyc);
      checks++;
      if (rsp_valid !== exp_rv) begin failures++; $display("FAIL rand_rsp_valid n=%0d got=%0b exp=%0b", n, rsp_valid, exp_rv); end
      if (exp_rv) begin
        checks++;
        if (rsp_id !== 2'(m_q[0].id) || rsp_data !== m_q[0].data) begin
          failures++; $display("FAIL rand_rsp n=%0d got id=%0d data=%0h exp id=%0d data=%0h", n, rsp_id, rsp_data, m_q[0].id, m_q[0].data);
        end
      end
      do_pop = exp_rv && rsp_ready;
      @(posedge clk);
      if (win >= 0) begin
        e.id = win; e.data = ref_result(req_op[2*win +: 2], req_a[8*win +: 8], req_b[8*win +: 8]); e.avail = m_cyc + 3;
        m_q.push_back(e); m_ptr = win; m_out++;
      end
      if (do_pop) begin void'(m_q.pop_front()); m_out--; end
      m_cyc++;
    end
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL rand_seq_err got=%0b exp=0", seq_err); end
  endtask

  task automatic test_seq_err();
    apply_reset();
    rsp_ready = 1'b1;
    @(negedge clk); drive_idle(); inject = 1'b1;
    @(negedge clk); inject = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (seq_err !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL seq_err_sticky k=%0d got err=%0b rv=%0b exp err=1 rv=0", k, seq_err, rsp_valid); end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    checks++;
    if (seq_err !== 1'b0) begin failures++; $display("FAIL seq_err_clear got=%0b exp=0", seq_err); end
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_random();
    test_seq_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
